// File: rtl/imm_rot_encoder.sv
// imm_rot_encoder: iterative search for an ARM immediate encoding.
// Finds the smallest rot (0..15) and an imm8 such that value == ROR(imm8, 2*rot).
// Produces operand12 = {rot, imm8} and the shifter carry-out.
// Optional macro IMM_ENC_INVERT_EN: after a failed direct pass, a second pass searches
// ~value (MOV/MVN substitution). A hit on that pass raises inv.
module imm_rot_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        c_in,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [11:0] operand12,
    output logic        c_out,
    output logic        inv
);

    typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] val_q, val_d;
    logic        cin_q, cin_d;
    logic [3:0]  r_q, r_d;
    logic        valid_q, valid_d;
    logic [11:0] op_q, op_d;
    logic        cout_q, cout_d;

    logic [31:0] v_cur;
    logic [63:0] rol_wide;
    logic [31:0] rol_v;
    logic        hit;

`ifdef IMM_ENC_INVERT_EN
    logic pass_q, pass_d;
    logic inv_q, inv_d;
    assign v_cur = pass_q ? ~val_q : val_q;
    assign inv   = inv_q;
`else
    assign v_cur = val_q;
    assign inv   = 1'b0;
`endif

    // Rotate left by 2r: the upper half of the doubled word shifted left.
    assign rol_wide = {v_cur, v_cur} << {r_q, 1'b0};
    assign rol_v    = rol_wide[63:32];
    assign hit      = (rol_v[31:8] == 24'd0);

    assign ready     = (state_q == StIdle);
    assign busy      = (state_q == StSearch);
    assign done      = (state_q == StDone);
    assign valid     = valid_q;
    assign operand12 = op_q;
    assign c_out     = cout_q;

    // Next-state: accept in IDLE, test one rotation per SEARCH cycle, one-cycle DONE.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        cin_d   = cin_q;
        r_d     = r_q;
        valid_d = valid_q;
        op_d    = op_q;
        cout_d  = cout_q;
`ifdef IMM_ENC_INVERT_EN
        pass_d  = pass_q;
        inv_d   = inv_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    val_d   = value;
                    cin_d   = c_in;
                    r_d     = 4'd0;
                    valid_d = 1'b0;
                    op_d    = 12'd0;
                    cout_d  = 1'b0;
`ifdef IMM_ENC_INVERT_EN
                    pass_d  = 1'b0;
                    inv_d   = 1'b0;
`endif
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (hit) begin
                    valid_d = 1'b1;
                    op_d    = {r_q, rol_v[7:0]};
                    // Carry comes from the original value even on the inverted pass.
                    cout_d  = (r_q == 4'd0) ? cin_q : val_q[31];
`ifdef IMM_ENC_INVERT_EN
                    inv_d   = pass_q;
`endif
                    state_d = StDone;
                end else if (r_q == 4'd15) begin
`ifdef IMM_ENC_INVERT_EN
                    if (!pass_q) begin
                        pass_d = 1'b1;
                        r_d    = 4'd0;
                    end else begin
                        state_d = StDone;
                    end
`else
                    state_d = StDone;
`endif
                end else begin
                    r_d = r_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            val_q   <= 32'd0;
            cin_q   <= 1'b0;
            r_q     <= 4'd0;
            valid_q <= 1'b0;
            op_q    <= 12'd0;
            cout_q  <= 1'b0;
`ifdef IMM_ENC_INVERT_EN
            pass_q  <= 1'b0;
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            cin_q   <= cin_d;
            r_q     <= r_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            cout_q  <= cout_d;
`ifdef IMM_ENC_INVERT_EN
            pass_q  <= pass_d;
            inv_q   <= inv_d;
`endif
        end
    end

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Self-checking bench for imm_rot_encoder (honours IMM_ENC_INVERT_EN if defined).
module tb_imm_rot_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] value;
    logic        c_in;
    logic        ready, busy, done, valid, c_out, inv;
    logic [11:0] operand12;

    int checks = 0;
    int errors = 0;

    imm_rot_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .value     (value),
        .c_in      (c_in),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .valid     (valid),
        .operand12 (operand12),
        .c_out     (c_out),
        .inv       (inv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        int k;
        k = s % 32;
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    // Reference: smallest rotation that brings the whole value into the low byte.
    task automatic model(input logic [31:0] v, input logic ci, output logic ev,
                         output logic [11:0] eop, output logic ec, output logic ei,
                         output int elat);
        logic [31:0] t;
        logic [3:0]  r4;
        bit found;
        found = 0; ev = 0; eop = 0; ec = 0; ei = 0; elat = 17;
        for (int r = 0; r < 16; r++) begin
            t = rotl(v, 2 * r);
            if (!found && t < 32'd256) begin
                found = 1; r4 = r[3:0];
                ev = 1; eop = {r4, t[7:0]}; ec = (r == 0) ? ci : v[31]; elat = r + 2;
            end
        end
`ifdef IMM_ENC_INVERT_EN
        if (!found) begin
            elat = 33;
            for (int r = 0; r < 16; r++) begin
                t = rotl(~v, 2 * r);
                if (!found && t < 32'd256) begin
                    found = 1; r4 = r[3:0];
                    ev = 1; ei = 1; eop = {r4, t[7:0]}; ec = (r == 0) ? ci : v[31];
                    elat = r + 18;
                end
            end
        end
`endif
    endtask

    // One request; optional stray start pulse at cycle pulse_cyc. Returns observed op/latency.
    task automatic run_req(input string tag, input logic [31:0] v, input logic ci,
                           input int pulse_cyc, output logic [11:0] got_op,
                           output logic got_v, output int got_lat);
        logic ev, ec, ei;
        logic [11:0] eop;
        int elat, cyc;
        model(v, ci, ev, eop, ec, ei, elat);
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        value = v; c_in = ci; start = 1'b1;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done === 1'b1) break;
            if (cyc == pulse_cyc) begin
                start = 1'b1; value = 32'h000000FF; c_in = ~ci;
            end
        end
        got_op = operand12; got_v = valid; got_lat = cyc;
        check({tag, "_lat"}, cyc, elat);
        check({tag, "_valid"}, {31'd0, valid}, {31'd0, ev});
        check({tag, "_op"}, {20'd0, operand12}, {20'd0, eop});
        check({tag, "_cout"}, {31'd0, c_out}, {31'd0, ec});
        check({tag, "_inv"}, {31'd0, inv}, {31'd0, ei});
        @(negedge clk);
        check({tag, "_post"}, {29'd0, ready, done, valid}, {29'd0, 1'b1, 1'b0, ev});
    endtask

    initial begin
        logic [11:0] op;
        logic        vld;
        int          lat;
        logic [31:0] rv;
        bit          saw_done;

        reset = 1'b1; start = 1'b0; value = '0; c_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {26'd0, ready, busy, done, valid, c_out, inv},
              {26'd0, 6'b100000});
        check("reset_op", {20'd0, operand12}, 32'd0);
        reset = 1'b0;

        run_req("ff", 32'h000000FF, 1'b1, -1, op, vld, lat);
        check("ff_spec", {op, lat[7:0]}, {12'h0FF, 8'd2});
        run_req("ff000000", 32'hFF000000, 1'b0, -1, op, vld, lat);
        check("ff000000_spec", {op, lat[7:0]}, {12'h4FF, 8'd6});
        run_req("104", 32'h00000104, 1'b1, -1, op, vld, lat);
        check("104_spec", {op, lat[7:0]}, {12'hF41, 8'd17});
        run_req("zero", 32'h00000000, 1'b1, -1, op, vld, lat);
        run_req("ffffff00", 32'hFFFFFF00, 1'b1, -1, op, vld, lat);
        run_req("101", 32'h00000101, 1'b0, -1, op, vld, lat);
        check("101_invalid", {20'd0, op, 3'd0, vld}, 32'd0);
        run_req("ignored_start", 32'h00000104, 1'b0, 3, op, vld, lat);
        check("ignored_spec", {op, lat[7:0]}, {12'hF41, 8'd17});

        // Reset in cycle 5 of a search: IDLE in cycle 6, no done pulse.
        @(negedge clk);
        value = 32'h00000104; c_in = 1'b1; start = 1'b1;
        saw_done = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) saw_done = 1;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset", {25'd0, saw_done, ready, busy, done, valid, c_out, inv},
              {25'd0, 7'b0100000});
        check("mid_reset_op", {20'd0, operand12}, 32'd0);

        // Reset and start together: request dropped.
        value = 32'h000000FF; start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        check("reset_start", {30'd0, ready, busy}, {30'd0, 2'b10});

        // Random encodable values, their complements, and raw random words.
        for (int i = 0; i < 8; i++) begin
            rv = rotl({24'd0, 8'($urandom_range(0, 255))}, 32 - 2 * $urandom_range(0, 15));
            run_req("rnd_enc", rv, 1'($urandom), -1, op, vld, lat);
            run_req("rnd_inv", ~rv, 1'($urandom), -1, op, vld, lat);
            run_req("rnd_raw", $urandom, 1'($urandom), -1, op, vld, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_rot_encoder.md
# imm_rot_encoder

Iterative encoder for ARM data-processing immediates: takes a 32-bit constant and searches for an 8-bit immediate and 4-bit rotate such that the constant equals `imm8` rotated right by `2*rot`. It produces the 12-bit `IR[11:0]` shifter-operand field plus the shifter carry-out, which is the inverse of the immediate-rotate path in `shifter`. It sits in the instruction-build/assembler-assist path, ahead of the decode/shift stage, and also serves as a reference model for checking `shifter`.

## Interface
- No parameters; width fixed at 32 bits.
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `start` in 1 — request; accepted only when `ready`=1.
- `value` in 32 — constant to encode; sampled on the accepting edge.
- `c_in` in 1 — current C flag; sampled with `value`.
- `ready` out 1 — high in IDLE.
- `busy` out 1 — high in SEARCH.
- `done` out 1 — one-cycle pulse when the result is valid.
- `valid` out 1 — 1 = encodable.
- `operand12` out 12 — `{rot[3:0], imm8[7:0]}`; 0 when `valid`=0.
- `c_out` out 1 — shifter carry: `c_in` if rot=0, else `value[31]`; 0 when `valid`=0.
- `inv` out 1 — encoding is of `~value` (MOV/MVN substitution); only with the macro, else tied 0.

## Operation
- FSM states: IDLE, SEARCH, DONE.
- IDLE: `start`=1 latches `value` and `c_in`, clears rot counter `r` to 0, clears pass bit, and moves to SEARCH.
- SEARCH: tests one `r` per cycle. Hit condition: `ROL(v, 2r)[31:8] == 0`, where `v` is the latched value, or its complement on the inverted pass.
  - On a hit: record `imm8 = ROL(v,2r)[7:0]`, `rot = r`, `valid` = 1, then go to DONE.
  - On a miss with `r`=15: end of pass (see Configuration), otherwise increment `r`.
- The smallest `r` wins, which is canonical. Value 0 gives rot=0, imm8=0.
- DONE: `done`=1 for exactly one cycle, then return to IDLE.
- `valid`, `operand12`, `c_out` and `inv` are registered. They update on the edge entering DONE and hold until the next accepted `start`.
- `start` in SEARCH or DONE is ignored, with no queueing.
- `c_out` is computed from the latched original `value[31]`, even when `inv`=1.

## Timing
- Reset: state IDLE; `ready`=1; `busy`, `done`, `valid`, `operand12`, `c_out`, `inv` all 0; `r`=0.
- Let cycle 0 be the cycle with `start`=1 in IDLE.
  - Rotation `r` is tested in cycle 1+r.
  - A hit at `r`=k puts `done` high in cycle k+2.
- Direct-pass miss: `done` in cycle 17 (without the macro).
- With the macro, inverted rotation k is tested in cycle 17+k. The worst case is `done` in cycle 33.
- `ready` returns high in the cycle after `done`. Back-to-back throughput is therefore k+3 cycles per request.
- `reset` during SEARCH or DONE: IDLE on the next edge, all outputs cleared, no `done` pulse.
- `reset` and `start` in the same cycle: `reset` wins and the request is dropped.

## Configuration
- `IMM_ENC_INVERT_EN` defined: after a failed direct pass, set the pass bit, reset `r`=0, and search `~value`.
  - A hit sets `inv`=1.
  - A miss on both passes gives `valid`=0 and `inv`=0.
- Undefined: single pass only. A direct-pass miss goes straight to DONE with `valid`=0. `inv` is constant 0.

## Test plan
- `value`=0x000000FF, `c_in`=1 -> `done` in cycle 2; `valid`=1, `operand12`=0x0FF, `c_out`=1, `inv`=0.
- `value`=0xFF000000, `c_in`=0 -> `done` in cycle 6; `operand12`=0x4FF, `c_out`=1.
- `value`=0x00000104 -> `done` in cycle 17; `operand12`=0xF41, `c_out`=0.
- `value`=0xFFFFFF00:
  - With the macro: `done` in cycle 18; `valid`=1, `inv`=1, `operand12`=0x0FF.
  - Without the macro: `done` in cycle 17; `valid`=0, `operand12`=0.
- `value`=0x00000101:
  - Without the macro: `valid`=0 in cycle 17.
  - With the macro: `valid`=0 and `inv`=0 in cycle 33.
- Start 0x00000104, then:
  - pulse `start` with 0xFF in cycle 3 -> ignored, result 0xF41 in cycle 17.
  - separate run: assert `reset` in cycle 5 -> IDLE in cycle 6, no `done`, all outputs 0, `ready`=1.
